// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
package sram_arb_pkg;

  localparam int ADDR_W = 18;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_HOLD
  } state_e;

endpackage

// File: rtl/sram_arb_pick.sv
// Winner selection between the two requesters.
// SRAM_ARB_FIXED_PRIO_EN: port 0 always wins; otherwise round-robin on last-served.
module sram_arb_pick
  import sram_arb_pkg::*;
(
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last,
  output logic o_winner
);

`ifdef SRAM_ARB_FIXED_PRIO_EN
  logic w_unused_last;
  assign w_unused_last = i_last;
  assign o_winner      = i_req0 ? PORT0 : PORT1;
`else
  always_comb begin
    // NOTE: default first so every path assigns o_winner and no latch is inferred.
    o_winner = PORT0;
    if (i_req0 && i_req1) o_winner = ~i_last;
    else if (i_req1)      o_winner = PORT1;
  end
`endif

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter for an asynchronous SRAM: IDLE -> SETUP -> ACCESS x WAIT_CYC -> HOLD.
// Define SRAM_ARB_FIXED_PRIO_EN to give port 0 absolute priority instead of round-robin.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              p0_req,
  input  logic              p1_req,
  input  logic              p0_we,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p0_wd,
  input  logic [DATA_W-1:0] p1_wd,
  output logic              p0_ack,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p0_rd,
  output logic [DATA_W-1:0] p1_rd,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wd,
  output logic              sram_wd_oe,
  input  logic [DATA_W-1:0] sram_rd,
  output logic              busy,
  output logic              gnt_port
);

  state_e           r_state, w_state_nx;
  logic [CNT_W-1:0] r_cnt;
  logic             r_last, r_gnt, r_we;
  logic             w_winner, w_load, w_last_acc;
  logic             w_we_nx, w_gnt_nx;
  logic             w_oe_n_nx, w_we_n_nx, w_wd_oe_nx, w_busy_nx, w_ack0_nx, w_ack1_nx;

  sram_arb_pick u_pick (
    .i_req0   (p0_req),
    .i_req1   (p1_req),
    .i_last   (r_last),
    .o_winner (w_winner)
  );

  assign w_load     = (r_state == ST_IDLE) && (p0_req || p1_req);
  assign w_last_acc = (r_state == ST_ACCESS) && (r_cnt == '0);

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      ST_IDLE:   if (p0_req || p1_req) w_state_nx = ST_SETUP;
      ST_SETUP:  w_state_nx = ST_ACCESS;
      ST_ACCESS: if (r_cnt == '0) w_state_nx = ST_HOLD;
      ST_HOLD:   w_state_nx = ST_IDLE;
      default:   w_state_nx = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so each pin leaves a flop in the cycle it applies to.
  always_comb begin
    w_we_nx    = w_load ? (w_winner ? p1_we : p0_we) : r_we;
    w_gnt_nx   = w_load ? w_winner : r_gnt;
    w_busy_nx  = (w_state_nx != ST_IDLE);
    w_wd_oe_nx = w_busy_nx && w_we_nx;
    w_oe_n_nx  = !((w_state_nx == ST_ACCESS) && !w_we_nx);
    w_we_n_nx  = !((w_state_nx == ST_ACCESS) && w_we_nx);
    w_ack0_nx  = (w_state_nx == ST_HOLD) && (w_gnt_nx == PORT0);
    w_ack1_nx  = (w_state_nx == ST_HOLD) && (w_gnt_nx == PORT1);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_last     <= PORT1;
      r_gnt      <= PORT0;
      r_we       <= 1'b0;
      sram_addr  <= '0;
      sram_wd    <= '0;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_wd_oe <= 1'b0;
      busy       <= 1'b0;
      p0_ack     <= 1'b0;
      p1_ack     <= 1'b0;
      p0_rd      <= '0;
      p1_rd      <= '0;
    end else begin
      r_state    <= w_state_nx;
      sram_oe_n  <= w_oe_n_nx;
      sram_we_n  <= w_we_n_nx;
      sram_wd_oe <= w_wd_oe_nx;
      busy       <= w_busy_nx;
      p0_ack     <= w_ack0_nx;
      p1_ack     <= w_ack1_nx;

      if (w_load) begin
        r_we      <= w_we_nx;
        r_gnt     <= w_winner;
        r_last    <= w_winner;
        sram_addr <= w_winner ? p1_addr : p0_addr;
        sram_wd   <= w_winner ? p1_wd : p0_wd;
      end

      if ((w_state_nx == ST_ACCESS) && (r_state != ST_ACCESS))
        r_cnt <= CNT_W'(WAIT_CYC - 1);
      else if ((r_state == ST_ACCESS) && (r_cnt != '0))
        r_cnt <= r_cnt - 1'b1;

      if (w_last_acc && !r_we) begin
        if (r_gnt == PORT1) p1_rd <= sram_rd;
        else                p0_rd <= sram_rd;
      end
    end
  end

  assign gnt_port = r_gnt;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: three instances (WAIT_CYC = 2, 1, 15) share clock and reset.
module tb_sram_arbiter;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        p0_req [N], p1_req [N], p0_we [N], p1_we [N];
  logic [17:0] p0_addr[N], p1_addr[N];
  logic [31:0] p0_wd  [N], p1_wd  [N];
  logic        p0_ack [N], p1_ack [N];
  logic [31:0] p0_rd  [N], p1_rd  [N];
  logic        sram_oe_n[N], sram_we_n[N], sram_wd_oe[N], busy[N], gnt_port[N];
  logic [17:0] sram_addr[N];
  logic [31:0] sram_wd[N], sram_rd[N];

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int          lat;
    bit          port;
    bit          both;
    int          we_low;
    int          oe_low;
    int          wdoe_hi;
    logic [17:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
  } obs_t;

  typedef struct {
    bit          port;
    bit          we;
    logic [17:0] addr;
    logic [31:0] data;
    int          lat;
    int          wc;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] model_rd(input logic [17:0] a);
    return (a == 18'h3FFFF) ? 32'h1234_5678 : ({a[13:0], a} ^ 32'h5A5A_0000);
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int W = (g == 0) ? 2 : ((g == 1) ? 1 : 15);
    assign sram_rd[g] = model_rd(sram_addr[g]);
    sram_arbiter #(.WAIT_CYC(W)) u_dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .p0_req     (p0_req[g]),
      .p1_req     (p1_req[g]),
      .p0_we      (p0_we[g]),
      .p1_we      (p1_we[g]),
      .p0_addr    (p0_addr[g]),
      .p1_addr    (p1_addr[g]),
      .p0_wd      (p0_wd[g]),
      .p1_wd      (p1_wd[g]),
      .p0_ack     (p0_ack[g]),
      .p1_ack     (p1_ack[g]),
      .p0_rd      (p0_rd[g]),
      .p1_rd      (p1_rd[g]),
      .sram_oe_n  (sram_oe_n[g]),
      .sram_we_n  (sram_we_n[g]),
      .sram_addr  (sram_addr[g]),
      .sram_wd    (sram_wd[g]),
      .sram_wd_oe (sram_wd_oe[g]),
      .sram_rd    (sram_rd[g]),
      .busy       (busy[g]),
      .gnt_port   (gnt_port[g])
    );
  end

  // Watches instance k from the current negedge until the next ack (or budget expiry, lat = -1).
  task automatic observe(input int k, input int budget, output obs_t o);
    o = '{lat: -1, port: 1'b0, both: 1'b0, we_low: 0, oe_low: 0, wdoe_hi: 0,
          addr: '0, wd: '0, rd: '0};
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (!sram_we_n[k]) o.we_low++;
      if (!sram_oe_n[k]) o.oe_low++;
      if (sram_wd_oe[k]) o.wdoe_hi++;
      if (!sram_we_n[k] || !sram_oe_n[k]) begin
        o.addr = sram_addr[k];
        o.wd   = sram_wd[k];
      end
      if (p0_ack[k] || p1_ack[k]) begin
        o.lat  = i;
        o.both = p0_ack[k] && p1_ack[k];
        o.port = p1_ack[k];
        o.rd   = p1_ack[k] ? p1_rd[k] : p0_rd[k];
        return;
      end
    end
  endtask

  function automatic logic [74:0] pack_obs(input obs_t o, input bit we);
    return {o.port, o.addr, o.lat[7:0], o.we_low[7:0], o.oe_low[7:0], we ? o.wd : o.rd};
  endfunction

  function automatic logic [74:0] pack_exp(input exp_t e);
    return {e.port, e.addr, e.lat[7:0], e.we ? e.wc[7:0] : 8'd0, e.we ? 8'd0 : e.wc[7:0], e.data};
  endfunction

  function automatic exp_t mk_exp(input bit port, input bit we, input logic [17:0] addr,
                                  input logic [31:0] wd, input int lat, input int wc);
    return '{port: port, we: we, addr: addr, data: we ? wd : model_rd(addr), lat: lat, wc: wc};
  endfunction

  task automatic test_reset();
    for (int k = 0; k < N; k++) begin
      n_vec++;
      if ({sram_oe_n[k], sram_we_n[k], sram_wd_oe[k], busy[k], gnt_port[k], p0_ack[k], p1_ack[k]}
          !== 7'b1100000) begin
        n_err++;
        $display("FAIL reset_ctrl inst%0d got {oe_n,we_n,wd_oe,busy,gnt,ack0,ack1}=%b want 1100000", k,
                 {sram_oe_n[k], sram_we_n[k], sram_wd_oe[k], busy[k], gnt_port[k], p0_ack[k], p1_ack[k]});
      end
      n_vec++;
      if ({sram_addr[k], sram_wd[k], p0_rd[k], p1_rd[k]} !== '0) begin
        n_err++;
        $display("FAIL reset_data inst%0d got addr=%h wd=%h rd0=%h rd1=%h want all zero", k,
                 sram_addr[k], sram_wd[k], p0_rd[k], p1_rd[k]);
      end
    end
  endtask

  task automatic test_contention();
    obs_t o;
    exp_t e;
    bit   port;
    p0_we[0] = 1'b1; p0_addr[0] = 18'h00123; p0_wd[0] = 32'hCAFE_0001;
    p1_we[0] = 1'b0; p1_addr[0] = 18'h02000;
    for (int i = 0; i < 4; i++) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
      port = 1'b0;
`else
      port = (i % 2 == 1);
`endif
      sb.push_back(port ? mk_exp(1'b1, 1'b0, p1_addr[0], '0, (i == 0) ? 4 : 5, 2)
                        : mk_exp(1'b0, 1'b1, p0_addr[0], p0_wd[0], (i == 0) ? 4 : 5, 2));
    end
    p0_req[0] = 1'b1;
    p1_req[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      observe(0, 40, o);
      if (i == 3) begin
        p0_req[0] = 1'b0;
        p1_req[0] = 1'b0;
      end
      e = sb.pop_front();
      n_vec++;
      if (pack_obs(o, e.we) !== pack_exp(e) || o.both) begin
        n_err++;
        $display("FAIL contention#%0d got port=%0d lat=%0d addr=%h data=%h both=%0d want port=%0d lat=%0d addr=%h data=%h",
                 i, o.port, o.lat, o.addr, e.we ? o.wd : o.rd, o.both, e.port, e.lat, e.addr, e.data);
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_write();
    obs_t o;
    exp_t e;
    p0_we[0] = 1'b1; p0_addr[0] = 18'h00010; p0_wd[0] = 32'hDEAD_BEEF;
    sb.push_back(mk_exp(1'b0, 1'b1, 18'h00010, 32'hDEAD_BEEF, 4, 2));
    p0_req[0] = 1'b1;
    observe(0, 40, o);
    p0_req[0] = 1'b0;
    e = sb.pop_front();
    n_vec++;
    if (pack_obs(o, e.we) !== pack_exp(e)) begin
      n_err++;
      $display("FAIL single_write got lat=%0d we_low=%0d oe_low=%0d addr=%h wd=%h want lat=4 we_low=2 oe_low=0 addr=%h wd=%h",
               o.lat, o.we_low, o.oe_low, o.addr, o.wd, e.addr, e.data);
    end
    n_vec++;
    if (o.wdoe_hi != 4) begin
      n_err++;
      $display("FAIL write_wd_oe_cycles got %0d want 4", o.wdoe_hi);
    end
    @(negedge clk);
    n_vec++;
    if ({sram_wd_oe[0], busy[0]} !== 2'b00) begin
      n_err++;
      $display("FAIL write_after_hold got {wd_oe,busy}=%b want 00", {sram_wd_oe[0], busy[0]});
    end
  endtask

  task automatic test_single_read();
    obs_t o;
    exp_t e;
    p1_we[0] = 1'b0; p1_addr[0] = 18'h3FFFF;
    sb.push_back(mk_exp(1'b1, 1'b0, 18'h3FFFF, '0, 4, 2));
    p1_req[0] = 1'b1;
    observe(0, 40, o);
    p1_req[0] = 1'b0;
    e = sb.pop_front();
    n_vec++;
    if (pack_obs(o, e.we) !== pack_exp(e)) begin
      n_err++;
      $display("FAIL single_read got port=%0d lat=%0d we_low=%0d oe_low=%0d rd=%h want port=1 lat=4 we_low=0 oe_low=2 rd=%h",
               o.port, o.lat, o.we_low, o.oe_low, o.rd, e.data);
    end
    repeat (3) @(negedge clk);
    n_vec++;
    if (p1_rd[0] !== 32'h1234_5678) begin
      n_err++;
      $display("FAIL read_hold got p1_rd=%h want 12345678", p1_rd[0]);
    end
  endtask

  task automatic test_reset_mid_access();
    obs_t o;
    exp_t e;
    bit   ack_seen = 1'b0;
    p0_we[0] = 1'b1; p0_addr[0] = 18'h00055; p0_wd[0] = 32'h0BAD_F00D;
    sb.push_back(mk_exp(1'b0, 1'b1, 18'h00055, 32'h0BAD_F00D, 4, 2));
    p0_req[0] = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({sram_we_n[0], sram_wd_oe[0]} !== 2'b01) begin
      n_err++;
      $display("FAIL pre_reset_access got {we_n,wd_oe}=%b want 01", {sram_we_n[0], sram_wd_oe[0]});
    end
    #1 reset_n = 1'b0;
    #1;
    n_vec++;
    if ({sram_oe_n[0], sram_we_n[0], sram_wd_oe[0], p0_ack[0], p1_ack[0], busy[0]} !== 6'b110000) begin
      n_err++;
      $display("FAIL reset_mid_access got {oe_n,we_n,wd_oe,ack0,ack1,busy}=%b want 110000",
               {sram_oe_n[0], sram_we_n[0], sram_wd_oe[0], p0_ack[0], p1_ack[0], busy[0]});
    end
    repeat (3) begin
      @(negedge clk);
      if (p0_ack[0] || p1_ack[0]) ack_seen = 1'b1;
    end
    n_vec++;
    if (ack_seen) begin
      n_err++;
      $display("FAIL ack_during_reset got ack=1 want 0");
    end
    reset_n = 1'b1;
    observe(0, 40, o);
    p0_req[0] = 1'b0;
    e = sb.pop_front();
    n_vec++;
    if (pack_obs(o, e.we) !== pack_exp(e)) begin
      n_err++;
      $display("FAIL served_after_reset got port=%0d lat=%0d addr=%h wd=%h want port=0 lat=4 addr=%h wd=%h",
               o.port, o.lat, o.addr, o.wd, e.addr, e.data);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_sweep(input int k, input int wc);
    obs_t o;
    exp_t e;
    p0_we[k] = 1'b0; p0_addr[k] = 18'h00A00 + 18'(k);
    p1_we[k] = 1'b1; p1_addr[k] = 18'h1F000 + 18'(k); p1_wd[k] = 32'h7700_0000 + 32'(wc);
    for (int i = 0; i < 3; i++) sb.push_back(mk_exp(1'b0, 1'b0, p0_addr[k], '0, (i == 0) ? wc + 2 : wc + 3, wc));
    p0_req[k] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      observe(k, 40, o);
      if (i == 2) p0_req[k] = 1'b0;
      e = sb.pop_front();
      n_vec++;
      if (pack_obs(o, e.we) !== pack_exp(e)) begin
        n_err++;
        $display("FAIL sweep_w%0d_read#%0d got lat=%0d oe_low=%0d we_low=%0d rd=%h want lat=%0d oe_low=%0d we_low=0 rd=%h",
                 wc, i, o.lat, o.oe_low, o.we_low, o.rd, e.lat, wc, e.data);
      end
    end
    @(negedge clk);
    sb.push_back(mk_exp(1'b1, 1'b1, p1_addr[k], p1_wd[k], wc + 2, wc));
    p1_req[k] = 1'b1;
    observe(k, 40, o);
    p1_req[k] = 1'b0;
    e = sb.pop_front();
    n_vec++;
    if (pack_obs(o, e.we) !== pack_exp(e)) begin
      n_err++;
      $display("FAIL sweep_w%0d_write got lat=%0d we_low=%0d oe_low=%0d wd=%h want lat=%0d we_low=%0d oe_low=0 wd=%h",
               wc, o.lat, o.we_low, o.oe_low, o.wd, e.lat, wc, e.data);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    for (int k = 0; k < N; k++) begin
      p0_req[k] = 1'b0; p1_req[k] = 1'b0; p0_we[k] = 1'b0; p1_we[k] = 1'b0;
      p0_addr[k] = '0; p1_addr[k] = '0; p0_wd[k] = '0; p1_wd[k] = '0;
    end
    repeat (2) @(negedge clk);
    test_reset();
    reset_n = 1'b1;
    @(negedge clk);
    test_contention();
    test_single_write();
    test_single_read();
    test_reset_mid_access();
    test_sweep(1, 1);
    test_sweep(2, 15);
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_leftover got %0d entries want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter WAIT_CYC, default 2, SHALL set the number of cycles the strobe stays low per access (legal range 1..15).
REQ-002 clk  input  1  single clock for all logic; rising-edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 p0_req, p1_req  input  1 each  access request, held high until ack.
REQ-005 p0_we, p1_we  input  1 each  1=write, 0=read; stable while req high.
REQ-006 p0_addr, p1_addr  input  18 each  word address; stable while req high.
REQ-007 p0_wd, p1_wd  input  32 each  write data; stable while req high.
REQ-008 p0_ack, p1_ack  output  1 each  one-cycle completion pulse.
REQ-009 p0_rd, p1_rd  output  32 each  read data, valid in the ack cycle and held until that port's next read ack.
REQ-010 sram_oe_n, sram_we_n  output  1 each  active-low SRAM strobes.
REQ-011 sram_addr  output  18  SRAM address.
REQ-012 sram_wd  output  32  SRAM write data; sram_wd_oe  output  1  data-bus drive enable.
REQ-013 sram_rd  input  32  SRAM read data.
REQ-014 busy  output  1  high in any state except IDLE; gnt_port  output  1  port currently served.

Function
REQ-015 The FSM SHALL have states IDLE, SETUP, ACCESS, HOLD.
REQ-016 IDLE: if any req is high, the block SHALL latch the winner's we/addr/wd and go to SETUP; otherwise it stays in IDLE.
REQ-017 SETUP (1 cycle): addr valid, both strobes high, sram_wd_oe = latched we.
REQ-018 ACCESS (WAIT_CYC cycles, counted by a 4-bit down-counter): sram_we_n low on writes, sram_oe_n low on reads.
REQ-019 On reads, sram_rd SHALL be registered on the last ACCESS cycle.
REQ-020 HOLD (1 cycle): both strobes high, addr/wd still driven, winner's ack high; next state IDLE.
REQ-021 Latency SHALL be exactly WAIT_CYC+2 cycles from the IDLE cycle that samples req to the ack cycle; an idle port SHALL achieve back-to-back accesses every WAIT_CYC+3 cycles.
REQ-022 Arbitration SHALL be round-robin: on simultaneous requests the port not served last wins; a lone requester always wins.
REQ-023 A req dropped by a requester before its ack SHALL NOT abort an access in progress; req is examined only in IDLE.
REQ-024 Both acks SHALL never be high in the same cycle.
REQ-025 Outputs SHALL be registered; sram_addr/sram_wd SHALL change only on entry to SETUP.

Reset
REQ-026 Reset SHALL set state=IDLE, sram_oe_n=1, sram_we_n=1, sram_wd_oe=0, sram_addr=0, sram_wd=0, acks=0, p0_rd=p1_rd=0, busy=0, gnt_port=0, and last-served=1 (port 0 wins the first contention).
REQ-027 Reset asserted mid-access SHALL immediately raise both strobes and drop sram_wd_oe, with no ack issued.

Configuration
REQ-028 With SRAM_ARB_FIXED_PRIO_EN defined, port 0 SHALL win every contention; without it, round-robin per REQ-022 applies.

Structure
REQ-029 Package sram_arb_pkg SHALL hold the state enum, ADDR_W=18, DATA_W=32, and the port-index constants.
REQ-030 One sub-module, sram_arb_pick, SHALL implement the winner selection: inputs are the two reqs and last-served, output is the winner (it contains the macro switch).

Verification
REQ-031 Single write: p0 write with addr=0x00010 and wd=0xDEADBEEF, WAIT_CYC=2 -> sram_we_n low for 2 cycles, p0_ack 4 cycles after req is sampled, sram_wd_oe high only during SETUP..HOLD.
REQ-032 Single read: p1 read at addr=0x3FFFF with the model returning 0x12345678 -> p1_ack and p1_rd=0x12345678 in the same cycle, sram_we_n never low.
REQ-033 Contention: both reqs held high continuously for 4 accesses -> acks alternate p0,p1,p0,p1; with SRAM_ARB_FIXED_PRIO_EN defined, p0 x4.
REQ-034 Reset mid-access: reset_n low during ACCESS -> strobes high and wd_oe low immediately, no ack; after release, a pending req is served normally.
REQ-035 Parameter sweep: WAIT_CYC=1 and WAIT_CYC=15 -> strobe low width equals WAIT_CYC, and the ack spacing under continuous requests equals WAIT_CYC+3.
